// File: rtl/frame_stream_loader.sv
// Frame front end: captures one N*N frame from a valid/ready stream, replays it
// to the controller write port at a fixed pace, then waits out the processing window.
module frame_stream_loader #(
    parameter int N           = 8,
    parameter int DW          = 8,
    parameter int PACE        = 2,
    parameter int WAIT_CYCLES = 320,
    parameter int AW          = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          wr_en,
    output logic [DW-1:0] data_out,
    output logic [AW-1:0] pix_addr,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   frame_count
);
    localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
    localparam int WW = $clog2(WAIT_CYCLES + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(N*N - 1);
    localparam logic [PW-1:0] PACE_LAST = PW'(PACE - 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [DW-1:0]   frame_buf_r [N*N];
    logic [AW-1:0]   fill_idx_r;
    logic [PW-1:0]   pace_cnt_r;
    logic [WW-1:0]   wait_cnt_r;
    logic [AW-1:0]   pix_addr_r;
    logic [DW-1:0]   data_out_r;
    logic            in_ready_r;
    logic            wr_en_r;
    logic            busy_r;
    logic            frame_done_r;
    logic [15:0]     frame_count_r;
    logic            accept_s;
    logic [AW-1:0]   next_pix_s;

    assign accept_s    = in_valid && in_ready_r && (state_r == ST_FILL);
    assign next_pix_s  = pix_addr_r + AW'(1);

    assign in_ready    = in_ready_r;
    assign wr_en       = wr_en_r;
    assign data_out    = data_out_r;
    assign pix_addr    = pix_addr_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FILL;
                else       state_s = ST_IDLE;
            end
            ST_FILL: begin
                if (accept_s && (fill_idx_r == LAST_IDX)) state_s = ST_STREAM;
                else                                      state_s = ST_FILL;
            end
            ST_STREAM: begin
                if ((pace_cnt_r == PACE_LAST) && (pix_addr_r == LAST_IDX)) state_s = ST_WAIT;
                else                                                       state_s = ST_STREAM;
            end
            ST_WAIT: begin
                if (wait_cnt_r == WW'(1)) state_s = ST_DONE;
                else                      state_s = ST_WAIT;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Frame storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            frame_buf_r[fill_idx_r] <= in_data;
        end
    end

    // Counters and registered outputs, all derived from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r    <= 1'b0;
            wr_en_r       <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= 16'd0;
            fill_idx_r    <= '0;
            pace_cnt_r    <= '0;
            wait_cnt_r    <= '0;
            pix_addr_r    <= '0;
            data_out_r    <= '0;
        end else begin
            in_ready_r   <= (state_s == ST_FILL);
            wr_en_r      <= (state_s == ST_STREAM);
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_s == ST_DONE);

            if (state_r == ST_WAIT && state_s == ST_DONE) begin
                frame_count_r <= frame_count_r + 16'd1;
            end

            if (state_r == ST_IDLE) begin
                fill_idx_r <= '0;
            end else if (accept_s) begin
                fill_idx_r <= fill_idx_r + AW'(1);
            end

            // Pixel 0 is presented in the very first stream cycle
            if (state_r == ST_FILL && state_s == ST_STREAM) begin
                pix_addr_r <= '0;
                data_out_r <= frame_buf_r[0];
                pace_cnt_r <= '0;
            end else if (state_r == ST_STREAM && state_s == ST_STREAM) begin
                if (pace_cnt_r == PACE_LAST) begin
                    pace_cnt_r <= '0;
                    pix_addr_r <= next_pix_s;
                    data_out_r <= frame_buf_r[next_pix_s];
                end else begin
                    pace_cnt_r <= pace_cnt_r + PW'(1);
                end
            end

            if (state_r == ST_STREAM && state_s == ST_WAIT) begin
                wait_cnt_r <= WAIT_INIT;
            end else if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r - WW'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_stream_loader.sv
// Directed bench: an 8x8/PACE=2 instance driven by hand sequences and a
// 4x4/PACE=1/WAIT=1 instance driven from a per-cycle vector table.
module tb_frame_stream_loader;
    logic        clk;
    logic        rst_n;

    logic        start8, valid8, ready8, wr8, busy8, done8;
    logic [7:0]  in8, dout8;
    logic [5:0]  addr8;
    logic [15:0] cnt8;

    logic        start4, valid4, ready4, wr4, busy4, done4;
    logic [7:0]  in4, dout4;
    logic [3:0]  addr4;
    logic [15:0] cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    frame_stream_loader #(.N(8), .DW(8), .PACE(2), .WAIT_CYCLES(320)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(valid8), .in_ready(ready8),
        .in_data(in8), .wr_en(wr8), .data_out(dout8), .pix_addr(addr8), .busy(busy8),
        .frame_done(done8), .frame_count(cnt8)
    );

    frame_stream_loader #(.N(4), .DW(8), .PACE(1), .WAIT_CYCLES(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(valid4), .in_ready(ready4),
        .in_data(in4), .wr_en(wr4), .data_out(dout4), .pix_addr(addr4), .busy(busy4),
        .frame_done(done4), .frame_count(cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_wr;
        logic        e_busy;
        logic        e_done;
        logic [7:0]  e_data;
        logic [3:0]  e_addr;
        logic [15:0] e_count;
    } vec_t;

    vec_t tbl [35];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] d4(input int k);
        return 8'(k * 17 + 5);
    endfunction

    function automatic logic [7:0] pix8(input int kind, input int k);
        logic [7:0] v;
        if (kind == 0)      v = 8'(k);
        else if (kind == 1) v = 8'(160 + k);
        else                v = ~(8'(160 + k));
        return v;
    endfunction

    // Start a frame on dut8 from IDLE and feed 64 pixels, offering one every 'gap' cycles
    task automatic fill8(input int kind, input int gap);
        int k   = 0;
        int cyc = 0;
        @(negedge clk);
        check("idle_ready", 32'(ready8), 32'd0);
        check("idle_busy", 32'(busy8), 32'd0);
        start8 = 1'b1;
        while (k < 64 && cyc < 2000) begin
            @(negedge clk);
            start8 = 1'b0;
            valid8 = ((cyc % gap) == 0);
            in8    = valid8 ? pix8(kind, k) : 8'h33;
            if (cyc == 0) check("fill_ready_first", 32'(ready8), 32'd1);
            if (valid8 && ready8) k++;
            cyc++;
        end
        check("fill_handshakes", 32'(k), 32'd64);
        if (gap == 1) check("fill_cycles", 32'(cyc), 32'd64);
    endtask

    // Check the stream, wait window and completion of dut8, or reset it mid-stream
    task automatic stream8(input int kind, input int abort_pix, input logic pulse, input logic [15:0] exp_cnt);
        for (int s = 0; s < 128; s++) begin
            @(negedge clk);
            valid8 = 1'b0;
            in8    = 8'hC3;
            start8 = pulse && (s == 40);
            if (abort_pix >= 0 && s == 2 * abort_pix) begin
                check("pre_abort_addr", 32'(addr8), 32'(abort_pix));
                rst_n = 1'b0;
                #1;
                check("abort_wr", 32'(wr8), 32'd0);
                check("abort_busy", 32'(busy8), 32'd0);
                check("abort_ready", 32'(ready8), 32'd0);
                check("abort_data", 32'(dout8), 32'd0);
                check("abort_addr", 32'(addr8), 32'd0);
                check("abort_done", 32'(done8), 32'd0);
                check("abort_count", 32'(cnt8), 32'(exp_cnt));
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            check($sformatf("s%0d_wr", s), 32'(wr8), 32'd1);
            check($sformatf("s%0d_data", s), 32'(dout8), 32'(pix8(kind, s / 2)));
            check($sformatf("s%0d_addr", s), 32'(addr8), 32'(s / 2));
            check($sformatf("s%0d_ready", s), 32'(ready8), 32'd0);
        end
        for (int w = 0; w < 320; w++) begin
            @(negedge clk);
            start8 = pulse && (w == 100);
            check($sformatf("w%0d_wr", w), 32'(wr8), 32'd0);
            check($sformatf("w%0d_done", w), 32'(done8), 32'd0);
            check($sformatf("w%0d_ready", w), 32'(ready8), 32'd0);
            check($sformatf("w%0d_busy", w), 32'(busy8), 32'd1);
            check($sformatf("w%0d_addr", w), 32'(addr8), 32'd63);
            check($sformatf("w%0d_data", w), 32'(dout8), 32'(pix8(kind, 63)));
        end
        @(negedge clk);
        start8 = 1'b0;
        check("done_pulse", 32'(done8), 32'd1);
        check("done_count", 32'(cnt8), 32'(exp_cnt));
        check("done_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        check("after_done", 32'(done8), 32'd0);
        check("after_busy", 32'(busy8), 32'd0);
        check("after_count", 32'(cnt8), 32'(exp_cnt));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        start8 = 1'b0; valid8 = 1'b0; in8 = 8'h00;
        start4 = 1'b0; valid4 = 1'b0; in4 = 8'h00;

        // Table for dut4: vector i drives before edge i, outputs checked just after it
        for (int i = 0; i < 35; i++) begin
            tbl[i] = '{start: 1'b0, valid: 1'b0, data: 8'h00, e_ready: 1'b0, e_wr: 1'b0,
                       e_busy: 1'b1, e_done: 1'b0, e_data: 8'h00, e_addr: 4'd0, e_count: 16'd0};
        end
        tbl[0].start = 1'b1; tbl[0].valid = 1'b1; tbl[0].data = 8'hEE; tbl[0].e_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tbl[k+1].valid   = 1'b1;
            tbl[k+1].data    = d4(k);
            tbl[k+1].e_ready = (k < 15);
            tbl[k+1].e_wr    = (k == 15);
            tbl[k+1].e_data  = (k == 15) ? d4(0) : 8'h00;
        end
        for (int j = 1; j < 16; j++) begin
            tbl[16+j].start  = (j == 4);
            tbl[16+j].valid  = 1'b1;
            tbl[16+j].data   = 8'h55;
            tbl[16+j].e_wr   = 1'b1;
            tbl[16+j].e_data = d4(j);
            tbl[16+j].e_addr = 4'(j);
        end
        for (int i = 32; i < 35; i++) begin
            tbl[i].e_data  = d4(15);
            tbl[i].e_addr  = 4'd15;
            tbl[i].e_count = (i >= 33) ? 16'd1 : 16'd0;
            tbl[i].e_done  = (i == 33);
            tbl[i].e_busy  = (i != 34);
        end

        repeat (2) @(negedge clk);
        check("rst_wr", 32'(wr8), 32'd0);
        check("rst_ready", 32'(ready8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_data", 32'(dout8), 32'd0);
        check("rst_addr", 32'(addr8), 32'd0);
        check("rst_count", 32'(cnt8), 32'd0);
        rst_n = 1'b1;

        fill8(0, 1); stream8(0, 30, 1'b0, 16'd0);
        fill8(0, 1); stream8(0, -1, 1'b0, 16'd1);
        fill8(1, 3); stream8(1, -1, 1'b0, 16'd2);
        fill8(2, 1); stream8(2, -1, 1'b1, 16'd3);

        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            start4 = tbl[i].start;
            valid4 = tbl[i].valid;
            in4    = tbl[i].data;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready", i), 32'(ready4), 32'(tbl[i].e_ready));
            check($sformatf("v%0d_wr", i), 32'(wr4), 32'(tbl[i].e_wr));
            check($sformatf("v%0d_busy", i), 32'(busy4), 32'(tbl[i].e_busy));
            check($sformatf("v%0d_done", i), 32'(done4), 32'(tbl[i].e_done));
            check($sformatf("v%0d_data", i), 32'(dout4), 32'(tbl[i].e_data));
            check($sformatf("v%0d_addr", i), 32'(addr4), 32'(tbl[i].e_addr));
            check($sformatf("v%0d_count", i), 32'(cnt4), 32'(tbl[i].e_count));
        end
        start4 = 1'b0; valid4 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
